// File: rtl/enc_par_scheduler_if.sv
// rtl/enc_par_scheduler_if.sv - message-in / codeword-out stream bundle of the RS encoder scheduler
interface enc_par_scheduler_if #(
  parameter int EGF_DIM = 8,
  parameter int ENC_WID = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ENC_WID*EGF_DIM-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [ENC_WID*EGF_DIM-1:0] out_data;
  logic                       out_par;
  logic                       out_last;

  // master drives messages and sinks codewords; slave is the scheduler
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_par, out_last
  );
endinterface

// File: rtl/enc_par_scheduler.sv
// rtl/enc_par_scheduler.sv - sequences message beats then parity beats of one RS codeword
module enc_par_scheduler #(
  parameter int EGF_DIM     = 8,
  parameter int RSC_MSG_LEN = 224,
  parameter int RSC_PAR_LEN = 32,
  parameter int ENC_WID     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  enc_par_scheduler_if.slave             strm,
  output logic                           pro_clr_o,
  output logic                           pro_en_o,
  input  logic                           pro_finish_i,
  input  logic [RSC_PAR_LEN*EGF_DIM-1:0] par_buf_data_i,
  output logic                           err_o
);

  localparam int MSG_BEATS = RSC_MSG_LEN / ENC_WID;
  localparam int PAR_BEATS = RSC_PAR_LEN / ENC_WID;
  localparam int CNT_MAX   = (MSG_BEATS > PAR_BEATS) ? MSG_BEATS : PAR_BEATS;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BEAT_W    = ENC_WID * EGF_DIM;
  localparam int PAR_W     = RSC_PAR_LEN * EGF_DIM;
  localparam int PIDX_W    = (PAR_W > 1) ? $clog2(PAR_W) : 1;

  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BEATS - 1);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_BEATS - 1);

  typedef enum logic [1:0] {IDLE, MSG, WAIT, PAR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [PIDX_W-1:0]  par_base;
  logic [BEAT_W-1:0]  par_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q | (pro_finish_i && (state_q != WAIT));
    pro_clr_o      = 1'b0;
    pro_en_o       = 1'b0;
    strm.in_ready  = 1'b0;
    strm.out_valid = 1'b0;
    strm.out_data  = '0;
    strm.out_par   = 1'b0;
    strm.out_last  = 1'b0;
    par_base       = PIDX_W'(cnt_q) * PIDX_W'(BEAT_W);
    par_beat       = par_buf_data_i[par_base +: BEAT_W];

    case (state_q)
      IDLE: begin
        if (strm.in_valid) begin
          pro_clr_o = 1'b1;
          state_d   = MSG;
          cnt_d     = '0;
        end
      end
      MSG: begin
        // pass-through: a beat moves only when both ends can move it
        strm.in_ready  = strm.out_ready;
        strm.out_valid = strm.in_valid;
        strm.out_data  = strm.in_data;
        pro_en_o       = strm.in_valid && strm.out_ready;
        if (pro_en_o) begin
          if (cnt_q == MSG_LAST) begin
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (pro_finish_i) begin
          state_d = PAR;
        end
      end
      PAR: begin
        strm.out_valid = 1'b1;
        strm.out_par   = 1'b1;
        strm.out_data  = par_beat;
        strm.out_last  = (cnt_q == PAR_LAST);
        if (strm.out_ready) begin
          if (cnt_q == PAR_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_enc_par_scheduler.sv
// tb/tb_enc_par_scheduler.sv - self-checking bench for enc_par_scheduler
module tb_enc_par_scheduler;
  localparam int EGF_DIM     = 8;
  localparam int RSC_MSG_LEN = 8;
  localparam int RSC_PAR_LEN = 4;
  localparam int ENC_WID     = 2;
  localparam int MSG_BEATS   = RSC_MSG_LEN / ENC_WID;
  localparam int PAR_BEATS   = RSC_PAR_LEN / ENC_WID;
  localparam int BW          = ENC_WID * EGF_DIM;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          par;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pro_clr, pro_en, pro_finish, err;
  logic [RSC_PAR_LEN*EGF_DIM-1:0] par_buf_data;

  always #5 clk = ~clk;

  enc_par_scheduler_if #(.EGF_DIM(EGF_DIM), .ENC_WID(ENC_WID)) sif ();

  enc_par_scheduler #(
    .EGF_DIM(EGF_DIM), .RSC_MSG_LEN(RSC_MSG_LEN),
    .RSC_PAR_LEN(RSC_PAR_LEN), .ENC_WID(ENC_WID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .strm(sif),
    .pro_clr_o(pro_clr), .pro_en_o(pro_en), .pro_finish_i(pro_finish),
    .par_buf_data_i(par_buf_data), .err_o(err)
  );

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int clr_cnt, en_cnt;
  int last_out_cyc = -100;
  int first_in_cyc = -1;
  bit acc_in, acc_out, prev_stall, err_exp;
  logic smp_in_ready, smp_out_valid, smp_pro_en;
  logic [BW-1:0] prev_data, pending;
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample/check at negedge, return 1 time unit after posedge
  task automatic cyc();
    beat_t e;
    @(negedge clk);
    acc_in        = sif.in_valid && sif.in_ready;
    acc_out       = sif.out_valid && sif.out_ready;
    smp_in_ready  = sif.in_ready;
    smp_out_valid = sif.out_valid;
    smp_pro_en    = pro_en;
    chk("pro_en_vs_accept", pro_en, acc_in);
    if (sif.in_ready) chk("in_ready_needs_out_ready", sif.out_ready, 1);
    if (prev_stall && sif.out_valid) chk("stall_hold", sif.out_data, prev_data);
    chk("err", err, err_exp);
    if (acc_out) begin
      chk("beat_available", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", sif.out_data, e.data);
        chk("out_par", sif.out_par, e.par);
        chk("out_last", sif.out_last, e.last);
      end
      if (sif.out_last) last_out_cyc = cyc_n;
    end
    if (acc_in && first_in_cyc < 0) first_in_cyc = cyc_n;
    clr_cnt   += int'(pro_clr);
    en_cnt    += int'(pro_en);
    prev_stall = sif.out_valid && !sif.out_ready;
    prev_data  = sif.out_data;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sif.in_valid = 1'b0;
    sif.out_ready = 1'b1;
    repeat (n) cyc();
  endtask

  // stall_mode: 0 none, 1 three-cycle stalls on msg beat 1 and parity beat 0, 2 random
  task automatic codeword(input bit directed, input int stall_mode, input bit gap5,
                          input bit spur, input bit b2b, input bit chk_b2b,
                          input bit rst_mid, input int lat);
    logic [BW-1:0] beats [MSG_BEATS];
    logic [7:0]    sym   [RSC_PAR_LEN];
    beat_t         e;
    int i, j, budget, gap_left, st_msg, st_par;
    bit gapped, spur_done, stall_now, gap_now, spur_now;

    beats[0] = pending;
    for (int k = 1; k < MSG_BEATS; k++)
      beats[k] = directed ? {8'(2*k+2), 8'(2*k+1)} : BW'($urandom);
    for (int k = 0; k < RSC_PAR_LEN; k++)
      sym[k] = directed ? 8'(8'hA0 + k) : 8'($urandom);
    pending = BW'($urandom);
    clr_cnt = 0;
    en_cnt = 0;
    first_in_cyc = -1;
    for (int k = 0; k < MSG_BEATS; k++) begin
      e.data = beats[k]; e.par = 1'b0; e.last = 1'b0;
      exp_q.push_back(e);
    end

    i = 0; budget = 0; gap_left = 0; st_msg = 0; st_par = 0;
    gapped = 0; spur_done = 0;
    while (i < MSG_BEATS && budget < 200) begin
      if (gap5 && i == 2 && !gapped) begin gapped = 1; gap_left = 5; end
      gap_now   = (gap_left != 0);
      stall_now = (stall_mode == 1 && i == 1 && st_msg < 3);
      spur_now  = spur && i == 2 && !spur_done;
      sif.in_valid  = !gap_now;
      sif.in_data   = beats[i];
      sif.out_ready = stall_now ? 1'b0 : (stall_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      pro_finish    = spur_now;
      cyc();
      pro_finish = 1'b0;
      if (gap_now) begin chk("gap_out_valid", smp_out_valid, 0); gap_left--; end
      if (stall_now) begin
        chk("stall_in_ready", smp_in_ready, 0);
        chk("stall_pro_en", smp_pro_en, 0);
        st_msg++;
      end
      if (spur_now) begin err_exp = 1'b1; spur_done = 1; end
      if (acc_in) i++;
      budget++;
    end
    chk("msg_done", i, MSG_BEATS);
    if (chk_b2b) chk("b2b_idle_gap", first_in_cyc - last_out_cyc, 2);

    sif.in_valid  = b2b;
    sif.in_data   = pending;
    sif.out_ready = 1'b1;
    repeat (lat) begin
      cyc();
      chk("wait_out_valid", smp_out_valid, 0);
      chk("wait_in_ready", smp_in_ready, 0);
    end
    pro_finish = 1'b1;
    cyc();
    pro_finish = 1'b0;
    for (int k = 0; k < RSC_PAR_LEN; k++) par_buf_data[k*EGF_DIM +: EGF_DIM] = sym[k];
    for (int b = 0; b < PAR_BEATS; b++) begin
      for (int l = 0; l < ENC_WID; l++) e.data[l*EGF_DIM +: EGF_DIM] = sym[b*ENC_WID + l];
      e.par = 1'b1;
      e.last = (b == PAR_BEATS - 1);
      exp_q.push_back(e);
    end

    j = 0; budget = 0;
    while (j < PAR_BEATS && budget < 100) begin
      stall_now = (stall_mode == 1 && j == 0 && st_par < 3);
      sif.out_ready = stall_now ? 1'b0 : (stall_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_mid) begin
        chk("pre_rst_out_valid", sif.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_out_last", sif.out_last, 0);
        chk("rst_err", err, 0);
        err_exp = 1'b0;
        exp_q.delete();
        sif.in_valid = 1'b0;
        prev_stall = 1'b0;
        cyc();
        chk("rst_hold_out_valid", smp_out_valid, 0);
        rst_n = 1'b1;
        return;
      end
      cyc();
      chk("par_out_valid", smp_out_valid, 1);
      chk("par_in_ready", smp_in_ready, 0);
      if (stall_now) st_par++;
      if (acc_out) j++;
      budget++;
    end
    chk("par_done", j, PAR_BEATS);
    chk("pro_clr_count", clr_cnt, 1);
    chk("pro_en_count", en_cnt, MSG_BEATS);
    chk("exp_q_drained", exp_q.size(), 0);
  endtask

  initial begin
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b1;
    pro_finish    = 1'b0;
    par_buf_data  = '0;
    err_exp       = 1'b0;
    prev_stall    = 1'b0;
    pending       = 16'h0201;

    repeat (3) cyc();
    chk("reset_out_valid", smp_out_valid, 0);
    chk("reset_in_ready", smp_in_ready, 0);
    chk("reset_pro_clr", pro_clr, 0);
    rst_n = 1'b1;
    idle(2);

    codeword(1, 0, 0, 0, 0, 0, 0, 2);   // nominal directed data
    idle(2);
    codeword(0, 1, 0, 0, 0, 0, 0, 1);   // output backpressure
    idle(2);
    codeword(0, 0, 1, 0, 0, 0, 0, 3);   // input gap
    idle(2);
    codeword(0, 0, 0, 1, 0, 0, 0, 2);   // spurious pro_finish
    idle(3);
    chk("err_sticky", err, 1);
    codeword(0, 0, 0, 0, 1, 0, 0, 1);   // back-to-back pair
    codeword(0, 0, 0, 0, 0, 1, 0, 2);
    idle(2);
    codeword(0, 0, 0, 0, 0, 0, 1, 1);   // reset during parity
    idle(1);
    codeword(0, 0, 0, 0, 0, 0, 0, 2);
    for (int r = 0; r < 8; r++) begin
      codeword(0, 2, 1'($urandom_range(0, 1)), 0, 0, 0, 0, $urandom_range(1, 3));
      idle($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enc_par_scheduler.md
Name: enc_par_scheduler

Overview:
Sequences one Reed-Solomon codeword through the encoder output stream.
- Passes message beats from the input stream to the output stream and enables the parity processor on each accepted beat.
- Waits for the processor's pro_finish, then reads the parity buffer out beat by beat, with out_last on the final parity beat.
- Sits between the upstream message source, the parity processor/parity buffer pair and the downstream codeword sink.

Parameters:
- EGF_DIM, 8, symbol width in bits.
- RSC_MSG_LEN, 224, message symbols per codeword. Must be a multiple of ENC_WID.
- RSC_PAR_LEN, 32, parity symbols per codeword. Must equal ENC_PAR_BUF_DEP and be a multiple of ENC_WID.
- ENC_WID, 4, symbols per stream beat.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream message beat valid.
- in_ready  out  1  upstream beat accepted when in_valid && in_ready.
- in_data  in  ENC_WID x EGF_DIM  message beat.
- pro_clr  out  1  one-cycle pulse clearing the parity processor state.
- pro_en  out  1  processor consumes in_data this cycle.
- pro_finish  in  1  processor parity complete; the parity buffer loads on this edge.
- par_buf_data  in  RSC_PAR_LEN x EGF_DIM  registered parity buffer contents.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
- out_data  out  ENC_WID x EGF_DIM  codeword beat.
- out_par  out  1  current out beat is parity.
- out_last  out  1  final beat of the codeword.
- err  out  1  sticky protocol error.

Behaviour:
- Constants: MSG_BEATS = RSC_MSG_LEN/ENC_WID; PAR_BEATS = RSC_PAR_LEN/ENC_WID. beat_cnt width is clog2(max(MSG_BEATS, PAR_BEATS)).
- Reset: state IDLE, beat_cnt 0, err 0. All outputs are 0.
- FSM states: IDLE, MSG, WAIT, PAR. Registered state. Outputs are combinational from state/beat_cnt/handshake inputs.
- IDLE:
  - in_ready=0, out_valid=0.
  - When in_valid=1: pro_clr=1 for that cycle, next state MSG, beat_cnt<=0.
  - This costs one bubble cycle per codeword.
- MSG:
  - in_ready=out_ready; out_valid=in_valid; out_data=in_data; out_par=0; out_last=0.
  - pro_en = in_valid && out_ready. Input and output transfer atomically; there is no internal message storage.
  - On each transfer, beat_cnt++. On the transfer with beat_cnt==MSG_BEATS-1: beat_cnt<=0, next state WAIT.
- WAIT:
  - in_ready=0, out_valid=0.
  - When pro_finish=1, next state PAR. Parity buffer data is valid from the following cycle.
- PAR:
  - out_valid=1; out_par=1.
  - out_data lane j = par_buf_data[beat_cnt*ENC_WID + j] for j = 0..ENC_WID-1.
  - out_last=1 when beat_cnt==PAR_BEATS-1.
  - out_data is held stable while out_ready=0.
  - On a transfer, beat_cnt++. On the last transfer: beat_cnt<=0, next state IDLE.
  - Minimum codeword latency is 1 (IDLE) + MSG_BEATS + processor latency + PAR_BEATS cycles.
- pro_finish in any state other than WAIT is ignored for sequencing and sets err.
- err clears only on reset.
- in_valid deasserting mid-message (MSG): the FSM stays in MSG with beat_cnt held. There is no timeout.
- in_valid=1 during WAIT/PAR: not accepted (in_ready=0). The beat is taken in a later IDLE.
- pro_finish and the last message beat in the same cycle: the last beat advances to WAIT; pro_finish sets err (not yet in WAIT).
- Asynchronous reset mid-operation: immediate IDLE, counters 0, outputs 0. The partial codeword is discarded.
- Back-to-back codewords: PAR last transfer -> IDLE -> MSG. Exactly one idle cycle between out_last and the next message beat.

Test Plan:
- Bench configuration: RSC_MSG_LEN=8, RSC_PAR_LEN=4, ENC_WID=2, EGF_DIM=8.
- Nominal:
  - Stimulus: in_data beats {01,02},{03,04},{05,06},{07,08} with out_ready=1; pro_finish 2 cycles after the last beat; par_buf_data={A0,A1,A2,A3}.
  - Response: out beats {01,02}..{07,08} with out_par=0, then {A0,A1},{A2,A3} with out_par=1, out_last=1 only on {A2,A3}.
  - Response: pro_clr pulses once; pro_en high for exactly 4 cycles.
- Output backpressure:
  - Stimulus: out_ready=0 for 3 cycles during the second message beat and during the first parity beat.
  - Response: in_ready=0 and pro_en=0 on those cycles; out_data held stable; the beat sequence is unchanged; no beat is lost or duplicated.
- Input gaps: in_valid drops for 5 cycles after beat 2 -> the FSM remains in MSG; the output resumes with beat 3; beat_cnt is correct.
- Spurious pro_finish: pulse pro_finish while in MSG -> err=1 and stays 1; the sequence still completes correctly after the real pro_finish in WAIT.
- Reset mid-parity: assert rst_n=0 during the first parity beat -> out_valid=0 immediately; after release, a new codeword is processed normally with pro_clr pulsed.
- Back-to-back: two codewords with in_valid held high -> exactly one idle cycle after the first out_last; the second codeword's parity is taken from the updated par_buf_data.
